// File: rtl/stick_pkg.sv
// Shared types and constants for the channel arbiter slice.
package stick_pkg;

    localparam int unsigned CH_NUM = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CNTR_W = 10;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [CNTR_W-1:0] cntr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // First requester strictly after 'last', wrapping; returns 'last' when nothing requests.
    function automatic logic [CH_W-1:0] rr_pick(input logic [CH_NUM-1:0] req,
                                                 input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] pick;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= int'(CH_NUM); i++) begin
            idx = last + CH_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/chan_arb_if.sv
// Channel-side inputs and filler write port of chan_arb, grouped as one bus.
interface chan_arb_if;
    import stick_pkg::*;

    logic [CH_NUM-1:0]             i_ch_en;
    logic [CH_NUM-1:0][DATA_W-1:0] i_data;
    logic [CH_NUM-1:0]             i_vld;
    logic [CH_NUM-1:0][CNTR_W-1:0] i_cntr;
    logic [CH_NUM-1:0]             i_cmpl;
    logic                          o_wr_vld;
    logic                          i_wr_rdy;
    logic [ADDR_W-1:0]             o_wr_addr;
    logic [DATA_W-1:0]             o_wr_data;

    modport master (
        input  i_ch_en, i_data, i_vld, i_cntr, i_cmpl, i_wr_rdy,
        output o_wr_vld, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_ch_en, i_data, i_vld, i_cntr, i_cmpl, i_wr_rdy,
        input  o_wr_vld, o_wr_addr, o_wr_data
    );

endinterface

// File: rtl/chan_fifo.sv
// Single-clock synchronous FIFO of fifo_entry_t; pointers carry an extra wrap bit.
module chan_fifo
    import stick_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk20,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  fifo_entry_t din_i,
    output fifo_entry_t dout_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk20) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk20) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/chan_arb.sv
// Round-robin merge of four channel streams into one filler write port, with frame tracking.
// Optional per-channel accept counters when CHAN_ARB_STATS_EN is defined.
module chan_arb
    import stick_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk20,
    input  logic              rst,
    input  logic              i_msync_n,
    chan_arb_if.master        bus,
    output logic [CH_NUM-1:0] o_ovf,
    output logic              o_frame_done
`ifdef CHAN_ARB_STATS_EN
    ,
    output logic [CH_NUM*16-1:0] o_stat_cnt
`endif
);

    logic [2:0] sync_q;
    logic       msync_fall;

    always_ff @(posedge clk20) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], i_msync_n};
        end
    end

    // sync_q[1] is the synchronized level, sync_q[2] its previous value.
    assign msync_fall = sync_q[2] & ~sync_q[1];

    fifo_entry_t [CH_NUM-1:0] fifo_din;
    fifo_entry_t [CH_NUM-1:0] fifo_dout;
    logic [CH_NUM-1:0]        fifo_push;
    logic [CH_NUM-1:0]        fifo_pop;
    logic [CH_NUM-1:0]        fifo_empty;
    logic [CH_NUM-1:0]        fifo_full;
    logic [CH_NUM-1:0]        req_wr;

    assign req_wr    = bus.i_vld & bus.i_ch_en;
    assign fifo_push = req_wr & ~fifo_full;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_fifo
        assign fifo_din[c] = '{cntr: bus.i_cntr[c], data: bus.i_data[c]};

        chan_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk20   (clk20),
            .rst     (rst),
            .push_i  (fifo_push[c]),
            .pop_i   (fifo_pop[c]),
            .din_i   (fifo_din[c]),
            .dout_o  (fifo_dout[c]),
            .empty_o (fifo_empty[c]),
            .full_o  (fifo_full[c])
        );
    end

    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CH_W-1:0]   grant;
    logic              load_en;
    logic              any_req;

    assign load_en = ~wr_vld_q | bus.i_wr_rdy;
    assign any_req = ~&fifo_empty;
    assign grant   = rr_pick(~fifo_empty, last_grant_q);

    always_comb begin
        fifo_pop     = '0;
        wr_vld_d     = wr_vld_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            wr_vld_d = any_req;
            if (any_req) begin
                fifo_pop[grant] = 1'b1;
                addr_d          = {grant, fifo_dout[grant].cntr};
                data_d          = fifo_dout[grant].data;
                last_grant_d    = grant;
            end
        end
    end

    logic [CH_NUM-1:0] done_mask_q, done_mask_d;
    logic [CH_NUM-1:0] ovf_q, ovf_d;
    logic              frame_done_q;
    logic              frame_cond;

    assign frame_cond = (|bus.i_ch_en) && ((done_mask_q | ~bus.i_ch_en) == '1) &&
                        (&fifo_empty) && !wr_vld_q;

    // Fresh sets win over the msync / frame-completion clears.
    always_comb begin
        done_mask_d = ((frame_cond || msync_fall) ? '0 : done_mask_q) |
                      (bus.i_cmpl & bus.i_ch_en);
        ovf_d       = (msync_fall ? '0 : ovf_q) | (req_wr & fifo_full);
    end

    always_ff @(posedge clk20) begin
        if (rst) begin
            wr_vld_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_grant_q <= CH_W'(CH_NUM - 1);
            done_mask_q  <= '0;
            ovf_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_vld_q     <= wr_vld_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            done_mask_q  <= done_mask_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_cond;
        end
    end

    assign bus.o_wr_vld  = wr_vld_q;
    assign bus.o_wr_addr = addr_q;
    assign bus.o_wr_data = data_q;
    assign o_ovf         = ovf_q;
    assign o_frame_done  = frame_done_q;

`ifdef CHAN_ARB_STATS_EN
    logic [CH_NUM-1:0][15:0] stat_q, stat_d;
    logic                    accept;

    assign accept = wr_vld_q & bus.i_wr_rdy;

    always_comb begin
        stat_d = stat_q;
        for (int c = 0; c < int'(CH_NUM); c++) begin
            if (msync_fall) begin
                stat_d[c] = '0;
            end
            if (accept && (addr_q[ADDR_W-1 -: CH_W] == CH_W'(c)) && (stat_d[c] != 16'hFFFF)) begin
                stat_d[c] = stat_d[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk20) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign o_stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_chan_arb.sv
// Directed self-checking bench for chan_arb with immediate-assertion comparisons.
module tb_chan_arb;
    import stick_pkg::*;

    logic        clk20;
    logic        rst;
    logic        i_msync_n;
    logic [3:0]  o_ovf;
    logic        o_frame_done;
`ifdef CHAN_ARB_STATS_EN
    logic [63:0] o_stat_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    chan_arb_if bus ();

    chan_arb #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk20        (clk20),
        .rst          (rst),
        .i_msync_n    (i_msync_n),
        .bus          (bus),
        .o_ovf        (o_ovf),
        .o_frame_done (o_frame_done)
`ifdef CHAN_ARB_STATS_EN
        ,
        .o_stat_cnt   (o_stat_cnt)
`endif
    );

    initial clk20 = 1'b0;
    always #5 clk20 = ~clk20;

    task automatic step();
        @(posedge clk20);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int ch;
        int idx;

        rst          = 1'b1;
        i_msync_n    = 1'b1;
        bus.i_ch_en  = 4'hF;
        bus.i_vld    = '0;
        bus.i_cmpl   = '0;
        bus.i_wr_rdy = 1'b1;
        bus.i_data   = '0;
        bus.i_cntr   = '0;
        step();
        step();
        chk("rst_vld", 64'(bus.o_wr_vld), 64'd0);
        chk("rst_addr", 64'(bus.o_wr_addr), 64'd0);
        chk("rst_data", 64'(bus.o_wr_data), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_fdone", 64'(o_frame_done), 64'd0);
        rst = 1'b0;
        step();

        // All four channels saturated for 8 cycles: grant order 0,1,2,3 repeating.
        n = 0;
        for (int s = 0; s < 40; s++) begin
            if (s < 8) begin
                bus.i_vld = 4'hF;
                for (int c = 0; c < 4; c++) begin
                    bus.i_cntr[c] = 10'(c * 16 + s);
                    bus.i_data[c] = 32'hA000_0000 | (32'(c) << 16) | 32'(s);
                end
            end else begin
                bus.i_vld = '0;
            end
            step();
            if (bus.o_wr_vld) begin
                ch  = n % 4;
                idx = n / 4;
                chk("sat_addr", 64'(bus.o_wr_addr), 64'({2'(ch), 10'(ch * 16 + idx)}));
                chk("sat_data", 64'(bus.o_wr_data),
                    64'(32'hA000_0000 | (32'(ch) << 16) | 32'(idx)));
                n++;
            end
        end
        chk("sat_count", 64'(n), 64'd32);
        chk("sat_ovf", 64'(o_ovf), 64'd0);

        // Single word on channel 2.
        bus.i_vld     = 4'b0100;
        bus.i_cntr[2] = 10'h305;
        bus.i_data[2] = 32'hDEAD_BEEF;
        step();
        bus.i_vld = '0;
        chk("one_vld_k", 64'(bus.o_wr_vld), 64'd0);
        step();
        chk("one_vld_k1", 64'(bus.o_wr_vld), 64'd1);
        chk("one_addr", 64'(bus.o_wr_addr), 64'h0B05);
        chk("one_data", 64'(bus.o_wr_data), 64'hDEAD_BEEF);
        step();
        chk("one_vld_k2", 64'(bus.o_wr_vld), 64'd0);

        // Backpressure: channel 1 pushes 10 words into a depth-8 FIFO.
        bus.i_wr_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_vld     = 4'b0010;
            bus.i_cntr[1] = 10'h100 + 10'(i);
            bus.i_data[1] = 32'hC0DE_0000 + 32'(i);
            step();
        end
        bus.i_vld = '0;
        chk("bp_ovf", 64'(o_ovf), 64'h2);
        chk("bp_vld", 64'(bus.o_wr_vld), 64'd1);
        chk("bp_addr_hold", 64'(bus.o_wr_addr), 64'h0500);
        chk("bp_data_hold", 64'(bus.o_wr_data), 64'hC0DE_0000);

        // Master sync low for two cycles clears the sticky overflow three edges later.
        i_msync_n = 1'b0;
        step();
        step();
        i_msync_n = 1'b1;
        chk("ms_ovf_e2", 64'(o_ovf), 64'h2);
        chk("ms_addr_hold", 64'(bus.o_wr_addr), 64'h0500);
        step();
        chk("ms_ovf_e3", 64'(o_ovf), 64'h0);

        // Drain: exactly 9 words, the dropped tenth absent.
        bus.i_wr_rdy = 1'b1;
        for (int j = 0; j < 9; j++) begin
            chk("dr_vld", 64'(bus.o_wr_vld), 64'd1);
            chk("dr_addr", 64'(bus.o_wr_addr), 64'(12'h500 + 12'(j)));
            chk("dr_data", 64'(bus.o_wr_data), 64'(32'hC0DE_0000 + 32'(j)));
            step();
        end
        chk("dr_empty", 64'(bus.o_wr_vld), 64'd0);

        // Frame done with channels 0 and 2 enabled, channel 2 still holding words.
        bus.i_ch_en  = 4'b0101;
        bus.i_wr_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_vld     = 4'b0100;
            bus.i_cntr[2] = 10'h010 + 10'(i);
            bus.i_data[2] = 32'h2222_0000 + 32'(i);
            step();
        end
        bus.i_vld  = '0;
        bus.i_cmpl = 4'b0101;
        step();
        bus.i_cmpl = '0;
        chk("fd_early", 64'(o_frame_done), 64'd0);
        bus.i_wr_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("fd_addr", 64'(bus.o_wr_addr), 64'(12'h810 + 12'(j)));
            step();
            chk("fd_wait", 64'(o_frame_done), 64'd0);
        end
        chk("fd_idle", 64'(bus.o_wr_vld), 64'd0);
        step();
        chk("fd_pulse", 64'(o_frame_done), 64'd1);
        step();
        chk("fd_once", 64'(o_frame_done), 64'd0);

        // Reset in the middle of a four-channel burst.
        bus.i_ch_en = 4'hF;
        for (int s = 0; s < 3; s++) begin
            bus.i_vld = 4'hF;
            for (int c = 0; c < 4; c++) begin
                bus.i_cntr[c] = 10'(c * 16 + s);
                bus.i_data[c] = 32'h7700_0000 + 32'(c * 16 + s);
            end
            step();
        end
        rst = 1'b1;
        step();
        chk("mr_vld", 64'(bus.o_wr_vld), 64'd0);
        chk("mr_addr", 64'(bus.o_wr_addr), 64'd0);
        chk("mr_data", 64'(bus.o_wr_data), 64'd0);
        chk("mr_ovf", 64'(o_ovf), 64'd0);
        chk("mr_fdone", 64'(o_frame_done), 64'd0);
        rst       = 1'b0;
        bus.i_vld = '0;
        step();
        chk("mr_flushed", 64'(bus.o_wr_vld), 64'd0);
        bus.i_vld = 4'hF;
        for (int c = 0; c < 4; c++) begin
            bus.i_cntr[c] = 10'h3C0 + 10'(c);
            bus.i_data[c] = 32'h5500_0000 + 32'(c);
        end
        step();
        bus.i_vld = '0;
        step();
        chk("mr_first_vld", 64'(bus.o_wr_vld), 64'd1);
        chk("mr_first_addr", 64'(bus.o_wr_addr), 64'h03C0);
        chk("mr_first_data", 64'(bus.o_wr_data), 64'h5500_0000);
        step();
        chk("mr_second_addr", 64'(bus.o_wr_addr), 64'h07C1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chan_arb.md
# chan_arb

Round-robin arbiter that merges the four physical-channel data streams (`data_blk` outputs: 32-bit word, valid, 10-bit word counter, cycle-complete) into one write port for the channel memory filler. Each channel gets a small elastic FIFO, so simultaneous bursts from all four channels are absorbed without loss up to the FIFO depth. The block also tracks per-frame completion against the master sync, and sits in the `clk20` domain between the four `data_blk` instances and `mem_fill`.

## Interface
- `FIFO_DEPTH`, 8: words per channel FIFO; power of two, 4..64.
- `CH_NUM`, 4: number of channels; fixed at 4, the width of the channel field in the write address.
- `clk20`  in  1  channel master clock, 20 MHz; the only clock.
- `rst`  in  1  synchronous reset, active high.
- `i_ch_en`  in  4  per-channel enable; a disabled channel's `i_vld`/`i_cmpl` are ignored.
- `i_data_0..3`  in  32 each  channel data words.
- `i_vld`  in  4  per-channel data-valid strobe; one word per high cycle.
- `i_cntr_0..3`  in  10 each  channel word counter (`[9:8]` virtual channel, `[7:0]` word index).
- `i_cmpl`  in  4  per-channel end-of-cycle strobe.
- `i_msync_n`  in  1  master sync, asynchronous to `clk20`, active low, minimum 80 ns.
- `o_wr_vld`  out  1  write request to the memory filler.
- `i_wr_rdy`  in  1  filler accepts the word on a cycle where `o_wr_vld & i_wr_rdy`.
- `o_wr_addr`  out  12  `{ch[1:0], cntr[9:0]}`.
- `o_wr_data`  out  32  word.
- `o_ovf`  out  4  sticky per-channel overflow.
- `o_frame_done`  out  1  one-cycle pulse when the frame is fully drained.

## Operation
- `i_msync_n` passes through a 2-FF synchronizer followed by a falling-edge detector, giving `msync_fall`, a single-cycle strobe.
- **FIFO write:** at each edge where `i_vld[c] & i_ch_en[c]`, the word `{i_cntr_c, i_data_c}` is pushed into FIFO c.
  - If FIFO c is full, the word is dropped and `o_ovf[c]` is set.
  - A pop in the same cycle does not free a slot for that push: full is evaluated before the pop.
- **Output register:**
  - Holds one word.
  - Is loaded when empty or when the held word is accepted in that cycle.
  - While `o_wr_vld=1` and `i_wr_rdy=0`, the address and data are held stable.
- **Round-robin arbitration:**
  - Search order starts at `last_grant+1` mod 4 and takes the first non-empty FIFO.
  - `last_grant` updates on every load.
  - Emptiness is judged on the FIFO state before this cycle's push.
- **Completion tracking:**
  - `done_mask[c]` is set by `i_cmpl[c] & i_ch_en[c]`.
  - When `(done_mask | ~i_ch_en) == 4'hF`, all FIFOs are empty and `o_wr_vld=0`, `o_frame_done` pulses once, then `done_mask` clears.
  - If all channels are disabled, no pulse is generated.
- **On `msync_fall`:**
  - `done_mask` and `o_ovf` are cleared.
  - FIFOs and the output register are not flushed; stale words drain normally.
- **Simultaneous events:**
  - Overflow set in the same cycle as `msync_fall`: set wins, `o_ovf[c]=1`.
  - `i_cmpl` in the same cycle as `msync_fall`: the set wins.
  - `i_cmpl` arriving while FIFO c is non-empty: `done` is still counted, and the pulse waits for the drain.
- **Disabling a channel mid-frame:** its FIFO contents still drain.
- **Reset:** all FIFOs empty; `last_grant=3` (channel 0 has first priority); synchronizer flops = 1.
- **Reset values of outputs:** `o_wr_vld=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_ovf=0`, `o_frame_done=0`.
- **Reset mid-operation:** all words held are discarded, with no partial write.

## Timing
- **Input to output:** `i_vld` sampled at edge k gives `o_wr_vld=1` after edge k+1, provided the output register is free and no other channel wins.
- **Throughput:** one word per cycle while `i_wr_rdy=1`, regardless of the channel mix.
- **Fairness:** with four saturated channels, each channel is granted exactly once every 4 accepted words.
- **`msync_fall` latency:** asserts 3 edges after the falling edge of `i_msync_n` (2 synchronizer edges plus the detect edge).
- **`o_frame_done`:** asserts one cycle after the completion condition holds, registered.

## Configuration
- `CHAN_ARB_STATS_EN` defined:
  - Adds output `o_stat_cnt` (4×16 bits, flattened to 64): per-channel count of words accepted by the filler.
  - Counters saturate at `16'hFFFF`.
  - Counters clear on `msync_fall` or `rst`; a clear coinciding with an accept yields 1.
- Not defined: the port is absent and no counter logic is built.

## Structure
- **Shared package `stick_pkg`:**
  - `CH_NUM`.
  - Channel-index width constant (2).
  - Counter width (10).
  - Address width (12).
  - Packed FIFO entry type `{cntr[9:0], data[31:0]}` (42 bits).
- **Sub-module `chan_fifo`:** single-clock synchronous FIFO, instanced 4 times.
  - Ports: push, pop, din, dout, empty, full.
  - Pointers are log2 wide, plus an extra wrap bit for the full/empty decision.
- **Kept in `chan_arb` itself:** synchronizer, arbiter, output register, completion logic.

## Test plan
- **Single word:** channel 2, `i_vld` at edge 10 with `cntr=10'h305`, data `32'hDEADBEEF`, `i_wr_rdy=1` → `o_wr_vld` high only in the cycle after edge 11, with `o_wr_addr=12'hB05` and the data unchanged.
- **All channels saturated:** all 4 channels assert `i_vld` for 8 cycles, `i_wr_rdy=1` → 32 words accepted; grant order 0,1,2,3 repeating; `o_ovf=0`.
- **Backpressure and overflow:** `i_wr_rdy=0`; channel 1 pushes 10 words with `FIFO_DEPTH=8`.
  - Expect `o_ovf[1]=1`.
  - After `i_wr_rdy=1`: exactly 9 words delivered (1 held in the output register plus 8 in the FIFO), with the dropped counters absent.
  - Address and data stay stable while stalled.
- **Frame done:** `i_ch_en=4'b0101`; `i_cmpl` on channels 0 and 2 while channel 2's FIFO holds 3 words → `o_frame_done` pulses once, 1 cycle after the last accepted word.
- **Msync clear:** an overflowed channel, then `i_msync_n` low for 2 cycles → `o_ovf` clears 3 edges later; the FIFO contents are still delivered.
- **Reset mid-burst:** `rst` asserted during a burst → the next cycle has all outputs 0, and the first grant after reset goes to channel 0.
